lsu_mem_stage: RTL

Load/store unit for the 5-stage RISC-V pipeline: it consumes the M-stage memory request (address, store data, control) produced by the EX/MEM pipeline register and returns the load data that feeds the MEM/WB register. It performs byte/halfword/word alignment, byte-enable generation and load sign/zero extension. It drives a variable-latency data-memory bus with a request/ready and rvalid handshake. While an access is in flight it asserts a stall to the hazard logic.

---
 rtl/lsu_mem_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
// Load/store unit for the M stage of the 5-stage RISC-V pipeline. It takes
// the EX/MEM memory request, checks size and alignment, and drives one
// access on a variable-latency data bus with a ready/rvalid handshake. It
// returns extended load data for MEM/WB and stalls the pipeline while the
// access is in flight.
//
// Ports
//   clk, reset            pipeline clock, synchronous active-high reset
//   MemWriteM, MemReadM   store / load present in M (both high = store)
//   Funct3M               RV32I load/store funct3 (size and sign)
//   ALUResultM            byte address
//   WriteDataM            store data, low bits significant
//   ReadDataM             extended load data, valid in DONE, 0 otherwise
//   StallM                freeze F/D/E/M while the access is outstanding
//   MisalignedM           1-cycle pulse: misaligned address or illegal funct3
//   BusErrM               1-cycle pulse: bus timeout abort
//   mem_*                 registered bus request (word address, byte
//                         enables, lane-replicated write data) and bus
//                         ready/rvalid/rdata responses
module lsu_mem_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic        MemReadM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        MisalignedM,
   output logic        BusErrM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state, stateNext;
   logic [7:0]  waitCnt;
   logic [1:0]  offsetQ;
   logic [2:0]  funct3Q;
   logic [31:0] rdataQ;

   logic        accessPresent, legal, aligned, legalAligned;
   logic        timeoutHit, abort;
   logic [3:0]  beNext;
   logic [31:0] wdataNext;
   logic [7:0]  selByte;
   logic [15:0] selHalf;

   assign accessPresent = MemReadM | MemWriteM;
   assign legalAligned  = legal & aligned;
   assign timeoutHit    = (waitCnt == 8'(TIMEOUT - 1));

   // Size/sign decode. Stores (including read+write together) only accept
   // the three unsigned-agnostic sizes; the U-variants are load-only.
   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      legal   = 1'b0;
      aligned = 1'b0;
      case (Funct3M)
         3'b000: begin legal = 1'b1;       aligned = 1'b1;                      end
         3'b001: begin legal = 1'b1;       aligned = ~ALUResultM[0];            end
         3'b010: begin legal = 1'b1;       aligned = (ALUResultM[1:0] == 2'b00); end
         3'b100: begin legal = ~MemWriteM; aligned = 1'b1;                      end
         3'b101: begin legal = ~MemWriteM; aligned = ~ALUResultM[0];            end
         default: ;
      endcase
   end

   // Lane steering: data is replicated across the word so the byte enables
   // alone pick the lanes the memory writes.
   always_comb begin
      case (Funct3M[1:0])
         2'b00: begin
            beNext    = 4'b0001 << ALUResultM[1:0];
            wdataNext = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            beNext    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{WriteDataM[15:0]}};
         end
         default: begin
            beNext    = 4'b1111;
            wdataNext = WriteDataM;
         end
      endcase
   end

   // An abort only happens if the handshake we are waiting on did not
   // arrive in the cycle the counter reaches its limit; completion wins.
   always_comb begin
      stateNext = state;
      abort     = 1'b0;
      case (state)
         IDLE: if (accessPresent && legalAligned) stateNext = REQ;
         REQ: begin
            if (mem_ready)       stateNext = mem_we ? DONE : WAIT;
            else if (timeoutHit) begin stateNext = DONE; abort = 1'b1; end
         end
         WAIT: begin
            if (mem_rvalid)      stateNext = DONE;
            else if (timeoutHit) begin stateNext = DONE; abort = 1'b1; end
         end
         DONE: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign StallM      = ~reset & accessPresent & legalAligned & (state != DONE);
   assign MisalignedM = ~reset & accessPresent & ~legalAligned & (state == IDLE);
   assign BusErrM     = ~reset & abort;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         offsetQ   <= '0;
         funct3Q   <= '0;
         rdataQ    <= '0;
         waitCnt   <= '0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (stateNext == REQ) begin
                  mem_req   <= 1'b1;
                  mem_we    <= MemWriteM;
                  mem_addr  <= {ALUResultM[31:2], 2'b00};
                  mem_wdata <= wdataNext;
                  mem_be    <= beNext;
                  offsetQ   <= ALUResultM[1:0];
                  funct3Q   <= Funct3M;
                  rdataQ    <= '0;  // stores and aborts return zero
                  waitCnt   <= '0;
               end
            end
            REQ: begin
               waitCnt <= waitCnt + 8'd1;
               if (stateNext != REQ) mem_req <= 1'b0;
            end
            WAIT: begin
               waitCnt <= waitCnt + 8'd1;
               if (mem_rvalid)      rdataQ <= mem_rdata;
               else if (timeoutHit) rdataQ <= '0;
            end
            default: ;
         endcase
      end
   end

   // Load extension from the captured word; only driven in DONE.
   assign selByte = rdataQ[8*offsetQ +: 8];
   assign selHalf = offsetQ[1] ? rdataQ[31:16] : rdataQ[15:0];

   always_comb begin
      ReadDataM = '0;
      if (!reset && state == DONE) begin
         case (funct3Q)
            3'b000:  ReadDataM = {{24{selByte[7]}}, selByte};
            3'b100:  ReadDataM = {24'h0, selByte};
            3'b001:  ReadDataM = {{16{selHalf[15]}}, selHalf};
            3'b101:  ReadDataM = {16'h0, selHalf};
            default: ReadDataM = rdataQ;
         endcase
      end
   end

endmodule
